// File: rtl/y_mux2to1.sv
// Two-input SIZE-bit selector built from per-bit AND/OR/NOT gates.
// z = c ? b : a, bit for bit.
module y_mux2to1 #(
   parameter int SIZE = 32
) (
   output logic [SIZE-1:0] z,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            c
);

   logic c_n_s;

   assign c_n_s = ~c;

   // The a&b consensus term keeps agreeing inputs resolved when c is unknown.
   for (genvar i = 0; i < SIZE; i++) begin : g_bit
      assign z[i] = (a[i] & c_n_s) | (b[i] & c) | (a[i] & b[i]);
   end

endmodule

// File: rtl/y_mux4to1.sv
// Four-input SIZE-bit selector as a two-level tree of y_mux2to1.
// Define Y_MUX4TO1_REG_OUT_EN to register z (async active-low reset to zero).
module y_mux4to1 #(
   parameter int SIZE = 32
) (
   output logic [SIZE-1:0] z,
   input  logic [SIZE-1:0] a0,
   input  logic [SIZE-1:0] a1,
   input  logic [SIZE-1:0] a2,
   input  logic [SIZE-1:0] a3,
   input  logic [1:0]      c,
   input  logic            clk,
   input  logic            rst_n
);

   logic [SIZE-1:0] lo_s;
   logic [SIZE-1:0] hi_s;
   logic [SIZE-1:0] sel_s;

   y_mux2to1 #(.SIZE(SIZE)) u_lvl1_lo (.z(lo_s),  .a(a0),   .b(a1),   .c(c[0]));
   y_mux2to1 #(.SIZE(SIZE)) u_lvl1_hi (.z(hi_s),  .a(a2),   .b(a3),   .c(c[0]));
   y_mux2to1 #(.SIZE(SIZE)) u_lvl2    (.z(sel_s), .a(lo_s), .b(hi_s), .c(c[1]));

`ifdef Y_MUX4TO1_REG_OUT_EN
   logic [SIZE-1:0] z_r;

   // Output register; reset discards any pending capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_r <= {SIZE{1'b0}};
      end else begin
         z_r <= sel_s;
      end
   end

   assign z = z_r;
`else
   logic unused_s;

   assign unused_s = clk ^ rst_n;
   assign z        = sel_s;
`endif

endmodule

// File: tb/tb_y_mux4to1.sv
// Directed self-checking bench for y_mux4to1 at SIZE = 32, 1 and 64.
// Covers both the combinational and the Y_MUX4TO1_REG_OUT_EN build.
module tb_y_mux4to1;

   logic [31:0] a0, a1, a2, a3;
   logic [1:0]  c;
   logic        clk;
   logic        rst_n;
   logic [31:0] z32;
   logic [0:0]  z1;
   logic [63:0] z64;
   logic [0:0]  b0, b1, b2, b3;
   logic [63:0] w0, w1, w2, w3;
   int          total;
   int          bad;

   assign b0 = a0[0:0];
   assign b1 = a1[0:0];
   assign b2 = a2[0:0];
   assign b3 = a3[0:0];
   assign w0 = {32'h0000_0000, a0};
   assign w1 = {32'h0000_0000, a1};
   assign w2 = {32'h0000_0000, a2};
   assign w3 = {32'h0000_0000, a3};

   y_mux4to1 #(.SIZE(32)) u_dut32 (.z(z32), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
                                   .c(c), .clk(clk), .rst_n(rst_n));
   y_mux4to1 #(.SIZE(1))  u_dut1  (.z(z1),  .a0(b0), .a1(b1), .a2(b2), .a3(b3),
                                   .c(c), .clk(clk), .rst_n(rst_n));
   y_mux4to1 #(.SIZE(64)) u_dut64 (.z(z64), .a0(w0), .a1(w1), .a2(w2), .a3(w3),
                                   .c(c), .clk(clk), .rst_n(rst_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Let the output reflect the current inputs: one time unit, or the next edge when registered.
   task automatic settle();
`ifdef Y_MUX4TO1_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic test_reset();
`ifdef Y_MUX4TO1_REG_OUT_EN
      a0 = 32'h1111_1111; a1 = 32'h2222_2222; a2 = 32'hCAFE_F00D; a3 = 32'h4444_4444;
      c = 2'd2;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (z32 !== 32'h0000_0000) begin
         bad++; $display("FAIL reset_async_z32 got=%h want=%h", z32, 32'h0);
      end
      total++;
      if (z64 !== 64'h0 || z1 !== 1'b0) begin
         bad++; $display("FAIL reset_async_wide got=%h/%h want=0/0", z64, z1);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (z32 !== 32'h0000_0000) begin
         bad++; $display("FAIL reset_hold_before_edge got=%h want=%h", z32, 32'h0);
      end
      @(posedge clk);
      #1;
      total++;
      if (z32 !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL reset_first_capture got=%h want=%h", z32, 32'hCAFE_F00D);
      end
`else
      a0 = 32'h1111_1111; a1 = 32'h2222_2222; a2 = 32'h3333_3333; a3 = 32'h4444_4444;
      c = 2'd1;
      rst_n = 1'b0;
      #1;
      total++;
      if (z32 !== 32'h2222_2222) begin
         bad++; $display("FAIL reset_no_effect_low got=%h want=%h", z32, 32'h2222_2222);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (z32 !== 32'h2222_2222) begin
         bad++; $display("FAIL reset_no_effect_high got=%h want=%h", z32, 32'h2222_2222);
      end
`endif
   endtask

   task automatic test_sweep();
      logic [31:0] exp32 [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      logic [0:0]  exp1  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      a0 = 32'h1111_1111; a1 = 32'h2222_2222; a2 = 32'h3333_3333; a3 = 32'h4444_4444;
      for (int i = 0; i < 4; i++) begin
         c = i[1:0];
         settle();
         total++;
         if (z32 !== exp32[i]) begin
            bad++; $display("FAIL sweep32 c=%0d got=%h want=%h", i, z32, exp32[i]);
         end
         total++;
         if (z1 !== exp1[i]) begin
            bad++; $display("FAIL sweep1 c=%0d got=%h want=%h", i, z1, exp1[i]);
         end
         total++;
         if (z64 !== {32'h0000_0000, exp32[i]}) begin
            bad++; $display("FAIL sweep64 c=%0d got=%h want=%h", i, z64, {32'h0, exp32[i]});
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] va0 [10] = '{32'h0123_4567, 32'hFFFF_0000, 32'hA5A5_A5A5, 32'h0000_0001, 32'h8000_0000,
                                32'h1357_9BDF, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h7654_3210, 32'h0000_0000};
      logic [31:0] va1 [10] = '{32'h89AB_CDEF, 32'h0000_FFFF, 32'h5A5A_5A5A, 32'h0000_0002, 32'h4000_0000,
                                32'h2468_ACE0, 32'h0000_0000, 32'hF0F0_F0F0, 32'hFEDC_BA98, 32'hFFFF_FFFF};
      logic [31:0] va2 [10] = '{32'hDEAD_0001, 32'h1234_5678, 32'h3C3C_3C3C, 32'h0000_0004, 32'h2000_0000,
                                32'hCAFE_BABE, 32'hAAAA_AAAA, 32'h00FF_00FF, 32'h1111_2222, 32'h8000_0001};
      logic [31:0] va3 [10] = '{32'hBEEF_0002, 32'h9ABC_DEF0, 32'hC3C3_C3C3, 32'h0000_0008, 32'h1000_0000,
                                32'hFACE_FEED, 32'h5555_5555, 32'hFF00_FF00, 32'h3333_4444, 32'h7FFF_FFFE};
      logic [1:0]  vc  [10] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3};
      logic [31:0] ref_s;
      for (int i = 0; i < 10; i++) begin
         a0 = va0[i]; a1 = va1[i]; a2 = va2[i]; a3 = va3[i]; c = vc[i];
         case (vc[i])
            2'd0:    ref_s = va0[i];
            2'd1:    ref_s = va1[i];
            2'd2:    ref_s = va2[i];
            default: ref_s = va3[i];
         endcase
         settle();
         total++;
         if (z32 !== ref_s) begin
            bad++; $display("FAIL random32 i=%0d got=%h want=%h", i, z32, ref_s);
         end
         total++;
         if (z64 !== {32'h0000_0000, ref_s} || z1 !== ref_s[0:0]) begin
            bad++; $display("FAIL random_wide i=%0d got=%h/%h want=%h", i, z64, z1, ref_s);
         end
      end
   endtask

   task automatic test_equal_inputs();
      a0 = 32'hDEAD_BEEF; a1 = 32'hDEAD_BEEF; a2 = 32'hDEAD_BEEF; a3 = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         c = i[1:0];
         settle();
         total++;
         if (z32 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL equal_inputs c=%0d got=%h want=%h", i, z32, 32'hDEAD_BEEF);
         end
      end
   endtask

`ifdef Y_MUX4TO1_REG_OUT_EN
   task automatic test_hold_and_midreset();
      a0 = 32'hA0A0_A0A0; a1 = 32'hA1A1_A1A1; a2 = 32'hA2A2_A2A2; a3 = 32'hA3A3_A3A3;
      c = 2'd0;
      settle();
      c = 2'd3;
      #2;
      total++;
      if (z32 !== 32'hA0A0_A0A0) begin
         bad++; $display("FAIL hold_between_edges got=%h want=%h", z32, 32'hA0A0_A0A0);
      end
      @(posedge clk);
      #1;
      total++;
      if (z32 !== 32'hA3A3_A3A3) begin
         bad++; $display("FAIL hold_next_edge got=%h want=%h", z32, 32'hA3A3_A3A3);
      end
      c = 2'd1;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (z32 !== 32'h0000_0000) begin
         bad++; $display("FAIL midreset_async got=%h want=%h", z32, 32'h0);
      end
      @(posedge clk);
      #1;
      total++;
      if (z32 !== 32'h0000_0000) begin
         bad++; $display("FAIL midreset_held got=%h want=%h", z32, 32'h0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (z32 !== 32'hA1A1_A1A1) begin
         bad++; $display("FAIL midreset_recapture got=%h want=%h", z32, 32'hA1A1_A1A1);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      a0 = 32'h0; a1 = 32'h0; a2 = 32'h0; a3 = 32'h0;
      c = 2'd0;
      test_reset();
      test_sweep();
      test_random();
      test_equal_inputs();
`ifdef Y_MUX4TO1_REG_OUT_EN
      test_hold_and_midreset();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/y_mux4to1.md
Y_MUX4TO1 -- requirements
Module: y_mux4to1

Interface
REQ-001 Parameter SIZE, default 32; data width of a0..a3 and z, legal range 1..64.
REQ-002 clk  input  1  single clock; used only when Y_MUX4TO1_REG_OUT_EN is defined.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 z  output  SIZE  selected data.
REQ-005 a0  input  SIZE  data selected when c = 0.
REQ-006 a1  input  SIZE  data selected when c = 1.
REQ-007 a2  input  SIZE  data selected when c = 2.
REQ-008 a3  input  SIZE  data selected when c = 3.
REQ-009 c  input  2  select code, unsigned.
REQ-010 Positional port order SHALL be z, a0, a1, a2, a3, c, clk, rst_n, so six-port positional instantiations elaborate with clk/rst_n left unconnected.

Function
REQ-011 z SHALL equal a0, a1, a2, a3 for c = 0, 1, 2, 3 respectively, bit-for-bit across all SIZE bits.
REQ-012 Without the macro, z SHALL be purely combinational from a0..a3 and c, with zero-cycle latency and no state.
REQ-013 With the macro, z SHALL be the REQ-011 value captured on the rising edge of clk, giving one-cycle latency.
REQ-014 No selection priority beyond c SHALL exist; all four codes are legal and none is reserved.
REQ-015 When a0..a3 are all equal, z SHALL equal that value regardless of c.
REQ-016 If any bit of c is X or Z, z SHALL be X in simulation wherever the candidate inputs differ; no silent default to a0.
REQ-017 Selection SHALL be two-level:
- level 1: c[0] chooses a0/a1 and a2/a3;
- level 2: c[1] chooses between the two level-1 results.

Reset
REQ-018 With the macro, rst_n low SHALL asynchronously force z to all zeros, independent of clk.
REQ-019 With the macro, z SHALL hold zero until the first rising clk edge after rst_n deasserts.
REQ-020 With the macro, reset asserted mid-stream SHALL discard the pending capture; there is no recovery of the prior value.
REQ-021 Without the macro, rst_n SHALL have no effect on z.

Configuration
REQ-022 Macro Y_MUX4TO1_REG_OUT_EN defined: output register present (REQ-013, REQ-018 to REQ-020).
REQ-023 Macro Y_MUX4TO1_REG_OUT_EN undefined: combinational only; clk and rst_n are ignored and no flops are inferred.

Structure
REQ-024 No shared package SHALL be required; SIZE stays a module parameter.
REQ-025 The block SHALL use one sub-module, y_mux2to1 (parameter SIZE; ports z, a, b, c), with three instances:
- two level-1 instances;
- one level-2 instance.
REQ-026 y_mux2to1 SHALL implement z = c ? b : a per bit using a gate-level AND/OR/NOT generate loop over SIZE.
REQ-027 The optional output register SHALL live in y_mux4to1, after the level-2 instance.

Verification
REQ-028 Combinational build:
- a0=0x11111111, a1=0x22222222, a2=0x33333333, a3=0x44444444;
- sweep c = 0..3;
- z SHALL be 0x11111111, 0x22222222, 0x33333333, 0x44444444 after 1 time unit.
REQ-029 Combinational build:
- 10 random iterations of a0..a3 and c;
- z SHALL equal the reference selection, compared with ===, every iteration.
REQ-030 a0..a3 all 0xDEADBEEF, c toggled through all codes -> z SHALL stay 0xDEADBEEF throughout.
REQ-031 Registered build:
- rst_n=0 -> z=0 immediately, with no clk edge;
- release rst_n, apply c=2 with a2=0xCAFEF00D;
- z SHALL be 0 before the edge and 0xCAFEF00D after the first rising edge.
REQ-032 Registered build:
- change c between clk edges -> z SHALL not change until the next rising edge;
- assert rst_n mid-cycle -> z SHALL go to 0 asynchronously.
REQ-033 SIZE=1 and SIZE=64 builds -> REQ-028 pattern SHALL pass, truncated or zero-extended to SIZE.
